// File: rtl/display_window_generator.sv
// display_window_generator: 2-stage pipeline turning h/v counters into display_enable, pixel_x/y and aligned syncs.
// Define FRAME_COUNT_EN to add the 8-bit frame_count output.
module display_window_generator #(
    parameter int COUNTER_SIZE = 11,
    parameter logic [COUNTER_SIZE-1:0] H_START = COUNTER_SIZE'(216),
    parameter logic [COUNTER_SIZE-1:0] H_END = COUNTER_SIZE'(1016),
    parameter logic [COUNTER_SIZE-1:0] V_START = COUNTER_SIZE'(27),
    parameter logic [COUNTER_SIZE-1:0] V_END = COUNTER_SIZE'(627)
) (
    input logic control_clock,
    input logic reset_n,
    input logic [COUNTER_SIZE-1:0] counter_out_hsync,
    input logic [COUNTER_SIZE-1:0] counter_out_vsync,
    input logic h_sync,
    input logic v_sync,
    output logic h_sync_out,
    output logic v_sync_out,
    output logic display_enable,
    output logic [COUNTER_SIZE-1:0] pixel_x,
    output logic [COUNTER_SIZE-1:0] pixel_y,
    output logic frame_start
`ifdef FRAME_COUNT_EN
    ,output logic [7:0] frame_count
`endif
);
    logic h_act, v_act, hs1, vs1, fs1;
    logic [COUNTER_SIZE-1:0] dx, dy;
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_act <= 1'b0;
            v_act <= 1'b0;
            hs1 <= 1'b0;
            vs1 <= 1'b0;
            fs1 <= 1'b0;
            dx <= '0;
            dy <= '0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            display_enable <= 1'b0;
            pixel_x <= '0;
            pixel_y <= '0;
            frame_start <= 1'b0;
`ifdef FRAME_COUNT_EN
            frame_count <= 8'd0;
`endif
        end else begin
            h_act <= counter_out_hsync >= H_START && counter_out_hsync < H_END;
            v_act <= counter_out_vsync >= V_START && counter_out_vsync < V_END;
            hs1 <= h_sync;
            vs1 <= v_sync;
            fs1 <= counter_out_hsync == H_START && counter_out_vsync == V_START;
            dx <= counter_out_hsync - H_START;
            dy <= counter_out_vsync - V_START;
            h_sync_out <= hs1;
            v_sync_out <= vs1;
            display_enable <= h_act & v_act;
            pixel_x <= (h_act & v_act) ? dx : '0;
            pixel_y <= (h_act & v_act) ? dy : '0;
            frame_start <= fs1;
`ifdef FRAME_COUNT_EN
            // counts in the same edge that raises frame_start, wrapping naturally at 8 bits
            frame_count <= frame_count + 8'(fs1);
`endif
        end
    end
endmodule

// File: doc/display_window_generator.md
DISPLAY_WINDOW_GENERATOR -- requirements
Module: display_window_generator

Interface
REQ-001 SHALL have parameter COUNTER_SIZE, default 11, width of the incoming h/v counters and of pixel_x/pixel_y.
REQ-002 SHALL have parameters H_START 11'd216 and H_END 11'd1016: first active h count, and first inactive h count after it.
REQ-003 SHALL have parameters V_START 11'd27 and V_END 11'd627: first active v count, and first inactive v count after it.
REQ-004 SHALL have port control_clock, input, 1: pixel clock, rising edge; the block's one clock.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port counter_out_hsync, input, COUNTER_SIZE: horizontal counter from the H sync stage.
REQ-007 SHALL have port counter_out_vsync, input, COUNTER_SIZE: vertical counter from the V sync stage.
REQ-008 SHALL have ports h_sync and v_sync, input, 1 each: raw syncs from the sync generators.
REQ-009 SHALL have ports h_sync_out and v_sync_out, output, 1 each: syncs delayed to align with the pixel outputs.
REQ-010 SHALL have port display_enable, output, 1: high while the aligned pixel is inside the active window.
REQ-011 SHALL have ports pixel_x and pixel_y, output, COUNTER_SIZE each: active-window coordinates, zero outside the window.
REQ-012 SHALL have port frame_start, output, 1: one-cycle pulse on the first active pixel of each frame.

Function
REQ-013 SHALL use a 2-stage register pipeline; every output SHALL reflect its inputs sampled exactly 2 rising edges earlier.
REQ-014 Stage 1 SHALL register the following:
- h_active = (H_START <= counter_out_hsync < H_END), unsigned compare.
- v_active = (V_START <= counter_out_vsync < V_END), unsigned compare.
- the raw h_sync and v_sync.
- dx = counter_out_hsync - H_START and dy = counter_out_vsync - V_START, each truncated to COUNTER_SIZE bits.
REQ-015 Stage 2 SHALL register the following:
- display_enable = h_active & v_active.
- pixel_x = dx and pixel_y = dy when display_enable is 1, else 0.
- the delayed syncs.
REQ-016 frame_start SHALL be 1 for exactly one cycle, when the stage-1 sample had counter_out_hsync==H_START and counter_out_vsync==V_START; otherwise it SHALL be 0.
REQ-017 At H_END-1 the block SHALL still be active (pixel_x = H_END-H_START-1); at H_END it SHALL be inactive. V_END SHALL behave the same way.
REQ-018 Counter wrap to 0 SHALL need no special handling; the result is purely the range compare.
REQ-019 If a counter holds a value (e.g. the v counter is not enabled), the outputs SHALL hold steadily and frame_start SHALL repeat on every cycle where the compare holds.
REQ-020 H_START >= H_END or V_START >= V_END is illegal; display_enable SHALL then stay 0.

Reset
REQ-021 reset_n low SHALL immediately clear all pipeline registers and all outputs to 0, with no clock needed.
REQ-022 After reset_n deasserts mid-frame, outputs SHALL be valid from the 2nd rising edge; there SHALL be no spurious frame_start.

Configuration
REQ-023 Macro FRAME_COUNT_EN, when defined, SHALL add port frame_count, output, 8 bits.
- It SHALL reset to 0.
- It SHALL increment by 1 in the same cycle frame_start is asserted.
- It SHALL wrap from 255 to 0.
REQ-024 Without FRAME_COUNT_EN, the frame_count port and its register SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-025 Reset pulse mid-line -> all outputs 0 asynchronously; after release with h=300, v=100, display_enable=1, pixel_x=84, pixel_y=73 on the 2nd edge.
REQ-026 h counter sweeps 1014..1018 with v=100 -> display_enable 1,1,0,0,0 and pixel_x 798,799,0,0,0, each delayed 2 cycles.
REQ-027 h=216, v=27 applied for one cycle -> frame_start=1 for exactly one cycle, 2 edges later, with pixel_x=0, pixel_y=0.
REQ-028 h_sync and v_sync toggle pattern 1,0,1,1,0 -> identical pattern on h_sync_out and v_sync_out, shifted by exactly 2 cycles.
REQ-029 Full-frame run of 256 frames with FRAME_COUNT_EN defined -> frame_count wraps 255 to 0 in step with the 256th frame_start pulse.
REQ-030 v=700 (outside the window) with h sweeping the full line -> display_enable, pixel_x, pixel_y and frame_start stay 0.
